// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per cycle.
// Optional leading-zero blanking output enabled by defining BIN_TO_BCD_BLANK_EN.
module bin_to_bcd_seq #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [BIN_W-1:0]      i_bin_in,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd_out,
`ifdef BIN_TO_BCD_BLANK_EN
  output logic [DIGITS-1:0]     o_blank,
`endif
  output logic                  o_overflow
);

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam int unsigned BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             r_state;
  logic [BIN_W-1:0]   r_bin;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic               r_busy;
  logic               r_done;
  logic [BCD_W-1:0]   r_bcd_out;
  logic               r_overflow;

  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_bcd_nxt;
  logic               w_ovf_nxt;
  logic               w_last;

  // Correct every digit >= 5 before the shift so the doubling carries in decimal.
  always_comb begin
    w_adj = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      w_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? r_bcd[4*i +: 4] + 4'd3 : r_bcd[4*i +: 4];
    end
    w_bcd_nxt = {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
    w_ovf_nxt = r_ovf | w_adj[BCD_W-1];
    w_last    = (r_cnt == CNT_W'(1));
  end

`ifdef BIN_TO_BCD_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

  logic [DIGITS-1:0]  r_blank;
  logic [DIGITS-1:0]  w_blank;
  logic               w_zero_run;

  always_comb begin
    w_blank    = '0;
    w_zero_run = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      w_zero_run = w_zero_run & (w_bcd_nxt[4*i +: 4] == 4'd0);
      w_blank[i] = w_zero_run;
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bcd_out  <= '0;
      r_overflow <= 1'b0;
`ifdef BIN_TO_BCD_BLANK_EN
      r_blank    <= BLANK_RST;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            r_state <= StShift;
            r_busy  <= 1'b1;
            r_bin   <= i_bin_in;
            r_bcd   <= '0;
            r_cnt   <= CNT_W'(BIN_W);
            r_ovf   <= 1'b0;
          end else begin
            r_state <= StIdle;
          end
        end
        StShift: begin
          r_bin <= {r_bin[BIN_W-2:0], 1'b0};
          r_bcd <= w_bcd_nxt;
          r_ovf <= w_ovf_nxt;
          r_cnt <= r_cnt - CNT_W'(1);
          // The final shift result goes straight to the output registers.
          if (w_last) begin
            r_state    <= StDone;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_bcd_out  <= w_ovf_nxt ? {DIGITS{4'h9}} : w_bcd_nxt;
            r_overflow <= w_ovf_nxt;
`ifdef BIN_TO_BCD_BLANK_EN
            r_blank    <= w_ovf_nxt ? '0 : w_blank;
`endif
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_bcd_out  = r_bcd_out;
  assign o_overflow = r_overflow;
`ifdef BIN_TO_BCD_BLANK_EN
  assign o_blank    = r_blank;
`endif

endmodule
